// File: rtl/isi_dem_pkg.sv
// Shared definitions for the unit-element selection logic: default sizes,
// the k-count width, the selector FSM state encoding and a saturation helper.
package isi_dem_pkg;

  localparam int N_ELEM = 18;
  localparam int SFI_W  = 4;
  localparam int K_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SELECT = 2'd2,
    ST_DONE   = 2'd3
  } sel_state_e;

  // Clamp a requested transition count to the number of available elements.
  function automatic logic [K_W-1:0] sat_count(input logic [K_W-1:0] req, input int limit);
    if (int'(req) > limit) return K_W'(limit);
    return req;
  endfunction

endpackage

// File: rtl/isi_argmin18.sv
// Combinational argmin over N unsigned W-bit values, skipping masked entries.
// Ties resolve to the lowest index; valid is low when every entry is masked.
module isi_argmin18
  import isi_dem_pkg::*;
#(
  parameter int N     = N_ELEM,
  parameter int W     = SFI_W,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0]   vals_i,
  input  logic [N-1:0]     mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [W-1:0]     val [N];
  logic [W-1:0]     best_val;
  logic [IDX_W-1:0] best_idx;
  logic             found;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign val[gi] = vals_i[gi*W +: W];
  end

  // Linear scan; strict less-than keeps the earliest index on ties.
  always_comb begin
    best_val = '1;
    best_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!mask_i[i] && (!found || (val[i] < best_val))) begin
        found    = 1'b1;
        best_val = val[i];
        best_idx = IDX_W'(i);
      end
    end
  end

  assign idx_o   = best_idx;
  assign valid_o = found;

endmodule

// File: rtl/isi_vq18_sel.sv
// Unit-element selector: on start, snapshots the loop-filter values and picks
// the min(k, N_ELEM) elements with the smallest values, one per enabled cycle,
// then publishes the registered up-transition vector st with a done pulse.
// Optional feature macro: ISI_SEL_MASK_EN adds elem_mask (excluded elements)
// and a short flag pulsed with done when too few elements were eligible.
module isi_vq18_sel
  import isi_dem_pkg::*;
#(
  parameter int N_ELEM = isi_dem_pkg::N_ELEM,
  parameter int SFI_W  = isi_dem_pkg::SFI_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic [K_W-1:0]          k,
  input  logic [N_ELEM*SFI_W-1:0] sfi,
`ifdef ISI_SEL_MASK_EN
  input  logic [N_ELEM-1:0]       elem_mask,
  output logic                    short,
`endif
  output logic [N_ELEM-1:0]       st,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  sel_state_e                state_q, state_d;
  logic [SFI_W-1:0]          snap_q [N_ELEM];
  logic [N_ELEM*SFI_W-1:0]   snap_flat;
  logic [N_ELEM-1:0]         chosen_q, chosen_d;
  logic [N_ELEM-1:0]         work_q, work_d;
  logic [K_W-1:0]            rem_q, rem_d;
  logic                      snap_load;
  logic [K_W-1:0]            k_sat;
  logic [N_ELEM-1:0]         init_mask;
  logic [IDX_W-1:0]          am_idx;
  logic                      am_valid;
  logic                      fin;
  logic [N_ELEM-1:0]         st_q;
  logic                      done_q;
`ifdef ISI_SEL_MASK_EN
  logic                      exh_q, exh_d;
  logic                      short_q;
`endif

  assign k_sat = sat_count(k, N_ELEM);

  // Masked elements start the round already "chosen" so argmin never picks them.
`ifdef ISI_SEL_MASK_EN
  assign init_mask = elem_mask;
`else
  assign init_mask = '0;
`endif

  // Flatten the snapshot for the argmin block.
  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_flat
    assign snap_flat[gi*SFI_W +: SFI_W] = snap_q[gi];
  end

  isi_argmin18 #(
    .N     (N_ELEM),
    .W     (SFI_W),
    .IDX_W (IDX_W)
  ) u_argmin (
    .vals_i  (snap_flat),
    .mask_i  (chosen_q),
    .idx_o   (am_idx),
    .valid_o (am_valid)
  );

  // Next-state and working-datapath updates; nothing moves without clk_en.
  always_comb begin
    state_d   = state_q;
    chosen_d  = chosen_q;
    work_d    = work_q;
    rem_d     = rem_q;
    snap_load = 1'b0;
`ifdef ISI_SEL_MASK_EN
    exh_d     = exh_q;
`endif
    if (clk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          snap_load = 1'b1;
          chosen_d  = init_mask;
          work_d    = '0;
          rem_d     = k_sat;
`ifdef ISI_SEL_MASK_EN
          exh_d     = 1'b0;
`endif
          state_d   = (k_sat == '0) ? ST_DONE : ST_SELECT;
        end
        ST_SELECT: begin
          if (am_valid) begin
            work_d[am_idx]   = 1'b1;
            chosen_d[am_idx] = 1'b1;
            rem_d            = rem_q - K_W'(1);
            if (rem_q == K_W'(1)) state_d = ST_DONE;
          end else begin
            // No eligible element left: finish early with what we have.
`ifdef ISI_SEL_MASK_EN
            exh_d   = 1'b1;
`endif
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state and working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      chosen_q <= '0;
      work_q   <= '0;
      rem_q    <= '0;
`ifdef ISI_SEL_MASK_EN
      exh_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      chosen_q <= chosen_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
`ifdef ISI_SEL_MASK_EN
      exh_q    <= exh_d;
`endif
    end
  end

  // Per-element snapshot, captured once in LOAD so later sfi changes are ignored.
  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_snap
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        snap_q[gi] <= '0;
      end else if (snap_load) begin
        snap_q[gi] <= sfi[gi*SFI_W +: SFI_W];
      end
    end
  end

  // The enabled DONE cycle is the only place the published vector changes.
  assign fin = (state_q == ST_DONE) && clk_en;

  // Published outputs: st holds between rounds, done is a single-clock pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= '0;
      done_q  <= 1'b0;
`ifdef ISI_SEL_MASK_EN
      short_q <= 1'b0;
`endif
    end else begin
      done_q  <= fin;
`ifdef ISI_SEL_MASK_EN
      short_q <= fin & exh_q;
`endif
      if (fin) st_q <= work_q;
    end
  end

  assign st   = st_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);
`ifdef ISI_SEL_MASK_EN
  assign short = short_q;
`endif

endmodule

// File: tb/tb_isi_vq18_sel.sv
// Directed bench for isi_vq18_sel with a scoreboard of expected round results.
// Build with ISI_SEL_MASK_EN defined to also exercise the element mask.
module tb_isi_vq18_sel;

  localparam int N = 18;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           clk_en;
  logic           start;
  logic [4:0]     k;
  logic [N*W-1:0] sfi;
  logic [N-1:0]   st;
  logic           busy;
  logic           done;
`ifdef ISI_SEL_MASK_EN
  logic [N-1:0]   elem_mask;
  logic           short_o;
`endif

  always #5 clk = ~clk;

  isi_vq18_sel #(.N_ELEM(N), .SFI_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .start     (start),
    .k         (k),
    .sfi       (sfi),
`ifdef ISI_SEL_MASK_EN
    .elem_mask (elem_mask),
    .short     (short_o),
`endif
    .st        (st),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [N-1:0] st;
    int           lat;
    logic         shrt;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int ksat(input int kk);
    return (kk > N) ? N : kk;
  endfunction

  // Reference: element i is selected when fewer than k elements rank ahead of it
  // (smaller value, or equal value at a lower index).
  function automatic logic [N-1:0] model_st(input logic [N*W-1:0] s, input int kk);
    logic [N-1:0] r;
    int rank;
    r = '0;
    for (int i = 0; i < N; i++) begin
      rank = 0;
      for (int j = 0; j < N; j++) begin
        if ((s[j*W +: W] < s[i*W +: W]) || ((s[j*W +: W] == s[i*W +: W]) && (j < i))) rank++;
      end
      if (rank < ksat(kk)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // One round: push the expectation, drive start, wait (bounded) for done,
  // pop and compare, then confirm done does not repeat and st stays put.
  task automatic run_round(input string tag, input logic [4:0] kk, input logic [N*W-1:0] s,
                           input logic [N-1:0] exp_st, input logic exp_sh, input int exp_lat,
                           input bit toggle_en, input bit disturb);
    exp_t e;
    exp_t g;
    int cnt;
    bit seen;
    bit accepted;
    bit extra;
    logic [N-1:0] st_hold;
    e.st = exp_st; e.lat = exp_lat; e.shrt = exp_sh;
    sb.push_back(e);
    k = kk; sfi = s; start = 1'b1;
    cnt = 0; seen = 0; accepted = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      clk_en = (toggle_en && (c % 3 == 1)) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (clk_en) begin
        cnt++;
        if (!accepted) begin
          accepted = 1;
          start = 1'b0;
          check({tag, "_busy"}, 32'(busy), 32'd1);
        end
      end
      if (disturb) begin
        start = (cnt == 3);
        if (cnt == 3) sfi = ~s;
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    clk_en = 1'b1;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    g = sb.pop_front();
    check({tag, "_st"}, 32'(st), 32'(g.st));
    if (g.lat != 0) check({tag, "_latency"}, 32'(cnt), 32'(g.lat));
    if (!g.shrt) check({tag, "_popcount"}, 32'($countones(st)), 32'(ksat(int'(kk))));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
`ifdef ISI_SEL_MASK_EN
    check({tag, "_short"}, 32'(short_o), 32'(g.shrt));
`endif
    st_hold = st;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) extra = 1;
    end
    check({tag, "_single_done"}, 32'(extra), 32'd0);
    check({tag, "_st_hold"}, 32'(st), 32'(st_hold));
    $display("round %s k=%0d st=0x%05h latency=%0d", tag, kk, st, cnt);
  endtask

  logic [N*W-1:0] s;
  logic [4:0]     kr;
  bit             flag;

  initial begin
    rst = 1'b1; clk_en = 1'b0; start = 1'b0; k = '0; sfi = '0;
`ifdef ISI_SEL_MASK_EN
    elem_mask = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_st", 32'(st), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zeros except e3=1, e7=2, k=2: picks e0,e1 in 5 enabled cycles.
    s = '0; s[3*W +: W] = 4'd1; s[7*W +: W] = 4'd2;
    run_round("two_zeros", 5'd2, s, 18'h00003, 1'b0, 5, 0, 0);

    // Single minimum at e5.
    s = '1; s[5*W +: W] = 4'd0;
    run_round("single_min", 5'd1, s, 18'h00020, 1'b0, 4, 0, 0);

    // k=0 with gapped clk_en: 3 enabled cycles, empty vector.
    run_round("k_zero", 5'd0, s, 18'h00000, 1'b0, 3, 1, 0);

    // k above N_ELEM saturates: every element, 21 enabled cycles.
    for (int i = 0; i < N; i++) s[i*W +: W] = 4'($urandom_range(0, 15));
    run_round("k_sat", 5'd25, s, 18'h3FFFF, 1'b0, 21, 0, 0);

    // Extra start and sfi change mid-round must not disturb the result.
    for (int i = 0; i < N; i++) s[i*W +: W] = 4'((i * 7 + 3) % 16);
    run_round("disturb", 5'd5, s, model_st(s, 5), 1'b0, 8, 1, 1);

    // Reset in SELECT with k=10.
    k = 5'd10; sfi = s; start = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_st", 32'(st), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    flag = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done || busy) flag = 1;
    end
    check("rst_no_done", 32'(flag), 32'd0);
    $display("round rst_mid k=10 st=0x%05h busy=%0d", st, busy);

    s = '0; s[3*W +: W] = 4'd1; s[7*W +: W] = 4'd2;
    run_round("after_rst", 5'd2, s, 18'h00003, 1'b0, 5, 0, 0);

    // Randomised rounds against the rank model.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) s[i*W +: W] = 4'($urandom_range(0, 15));
      kr = 5'($urandom_range(1, 20));
      run_round("random", kr, s, model_st(s, int'(kr)), 1'b0, ksat(int'(kr)) + 3, (r == 1), 0);
    end

`ifdef ISI_SEL_MASK_EN
    // Only e0..e3 eligible, k=6: four picks and short with done.
    elem_mask = 18'h3FFF0;
    for (int i = 0; i < N; i++) s[i*W +: W] = 4'($urandom_range(0, 15));
    run_round("mask_short", 5'd6, s, 18'h0000F, 1'b1, 0, 0, 0);
    elem_mask = '0;
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
